// File: rtl/sseg_scan_decoder_pkg.sv
`default_nettype none
// ============================================================================
// Package     : sseg_pkg
// Description : Shared definitions for the seven-segment scan decoder:
//               segment pattern constants, pattern<->code mapping,
//               blank/illegal codes, anode-to-digit mapping and FSM states.
// Revision    : 1.0 - initial release
// ============================================================================
package sseg_pkg;

    // Segment patterns {g,f,e,d,c,b,a}, active-low, indexed by character code.
    localparam logic [6:0] SEG_PAT_0 = 7'b1000000;
    localparam logic [6:0] SEG_PAT_1 = 7'b0000111;
    localparam logic [6:0] SEG_PAT_2 = 7'b1111111;
    localparam logic [6:0] SEG_PAT_3 = 7'b1111001;
    localparam logic [6:0] SEG_PAT_4 = 7'b0001001;
    localparam logic [6:0] SEG_PAT_5 = 7'b0001000;
    localparam logic [6:0] SEG_PAT_6 = 7'b0010010;
    localparam logic [6:0] SEG_PAT_7 = 7'b1000111;
    // Code 8 is drawn identically to code 5, so it can never be told apart.
    localparam logic [6:0] SEG_PAT_8 = SEG_PAT_5;
    localparam logic [6:0] SEG_PAT_9 = 7'b0100100;

    localparam logic [3:0]  BLANK_CODE   = 4'h2;
    localparam logic [3:0]  ILLEGAL_CODE = 4'hF;
    localparam logic [15:0] BLANK_FRAME  = {4{BLANK_CODE}};

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_HOLD   = 2'd2
    } sseg_state_e;

    // an[3] drives the rightmost digit (digit 0), an[0] the leftmost (digit 3).
    function automatic logic [1:0] an_to_digit(input logic [3:0] an);
        logic [1:0] idx;
        case (an)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            4'b0001: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

    function automatic logic an_is_onehot(input logic [3:0] an);
        return (an != 4'b0000) && ((an & (an - 4'd1)) == 4'b0000);
    endfunction

    // Reverse table, for driver-side benches that need to generate patterns.
    function automatic logic [6:0] code_to_pattern(input logic [3:0] code);
        logic [6:0] pat;
        case (code)
            4'd0:    pat = SEG_PAT_0;
            4'd1:    pat = SEG_PAT_1;
            4'd2:    pat = SEG_PAT_2;
            4'd3:    pat = SEG_PAT_3;
            4'd4:    pat = SEG_PAT_4;
            4'd5:    pat = SEG_PAT_5;
            4'd6:    pat = SEG_PAT_6;
            4'd7:    pat = SEG_PAT_7;
            4'd8:    pat = SEG_PAT_8;
            4'd9:    pat = SEG_PAT_9;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sseg_scan_decoder_if.sv
`default_nettype none
// ============================================================================
// Interface   : sseg_scan_decoder_if
// Description : Display-side lines (segments, decimal point, anodes) and the
//               reconstructed-frame outputs of the scan decoder. The master
//               is the display driver / stimulus, the slave is the decoder.
// Revision    : 1.0 - initial release
// ============================================================================
interface sseg_scan_decoder_if #(
    parameter int CNT_W = 8
) ();

    logic [6:0]       seg_n;
    logic             dp_n;
    logic [3:0]       an;

    logic [15:0]      char_out;
    logic [3:0]       digit_valid;
    logic [3:0]       dp_out;
    logic             frame_valid;
    logic             frame_changed;
    logic [CNT_W-1:0] scroll_count;
    logic             sel_error;

    modport master (
        output seg_n, dp_n, an,
        input  char_out, digit_valid, dp_out, frame_valid, frame_changed,
               scroll_count, sel_error
    );

    modport slave (
        input  seg_n, dp_n, an,
        output char_out, digit_valid, dp_out, frame_valid, frame_changed,
               scroll_count, sel_error
    );

endinterface
`default_nettype wire

// File: rtl/sseg_scan_decoder_pattern_decode.sv
`default_nettype none
// ============================================================================
// Module      : sseg_pattern_decode
// Description : Combinational 7-bit segment pattern to 4-bit character code
//               lookup. Unknown patterns return ILLEGAL_CODE.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_pattern_decode
    import sseg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] code_o
);

    // Table lookup; the pattern shared by codes 5 and 8 always yields 5.
    always_comb begin
        code_o = ILLEGAL_CODE;
        case (seg_i)
            SEG_PAT_0: code_o = 4'd0;
            SEG_PAT_1: code_o = 4'd1;
            SEG_PAT_2: code_o = 4'd2;
            SEG_PAT_3: code_o = 4'd3;
            SEG_PAT_4: code_o = 4'd4;
            SEG_PAT_5: code_o = 4'd5;
            SEG_PAT_6: code_o = 4'd6;
            SEG_PAT_7: code_o = 4'd7;
            SEG_PAT_9: code_o = 4'd9;
            default:   code_o = ILLEGAL_CODE;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : sseg_scan_decoder
// Description : Samples the lines of a 4-digit multiplexed seven-segment
//               display, rejects ghosting while digits switch, rebuilds the
//               4-character frame and flags frame changes (scroll steps).
//               Optional macro SSEG_DP_CAPTURE_EN: when defined the decimal
//               point takes part in stability matching and is captured per
//               digit; otherwise dp_n is ignored and dp_out reads 0.
// Revision    : 1.0 - initial release
// ============================================================================
module sseg_scan_decoder
    import sseg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 1024,   // must be >= 2
    parameter int TIMEOUT_CYCLES = 2**20,
    parameter int CNT_W          = 8
) (
    input  logic                clock,
    input  logic                reset,
    sseg_scan_decoder_if.slave  bus
);

    localparam int CNT_BITS = $clog2(STABLE_CYCLES + 1);
    localparam int WD_BITS  = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_BITS-1:0] CNT_LAST = CNT_BITS'(STABLE_CYCLES - 1);
    localparam logic [CNT_BITS-1:0] CNT_ONE  = CNT_BITS'(1);
    localparam logic [WD_BITS-1:0]  WD_LAST  = WD_BITS'(TIMEOUT_CYCLES - 1);
`ifdef SSEG_DP_CAPTURE_EN
    localparam int SMP_W = 12;
`else
    localparam int SMP_W = 11;
`endif

    // ------------------------------------------------------------------
    // Input synchronisers
    // ------------------------------------------------------------------
    logic [3:0] an_s1_q,  an_s2_q;
    logic [6:0] seg_s1_q, seg_s2_q;

    // Two-stage synchroniser on anode and segment lines.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            an_s1_q  <= 4'b0000;
            an_s2_q  <= 4'b0000;
            seg_s1_q <= 7'h7F;
            seg_s2_q <= 7'h7F;
        end else begin
            an_s1_q  <= bus.an;
            an_s2_q  <= an_s1_q;
            seg_s1_q <= bus.seg_n;
            seg_s2_q <= seg_s1_q;
        end
    end

    logic [SMP_W-1:0] sample;

`ifdef SSEG_DP_CAPTURE_EN
    logic dp_s1_q, dp_s2_q;

    // Two-stage synchroniser on the decimal point line.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            dp_s1_q <= 1'b1;
            dp_s2_q <= 1'b1;
        end else begin
            dp_s1_q <= bus.dp_n;
            dp_s2_q <= dp_s1_q;
        end
    end

    assign sample = {an_s2_q, seg_s2_q, dp_s2_q};
`else
    assign sample = {an_s2_q, seg_s2_q};
`endif

    // ------------------------------------------------------------------
    // Decode and decision terms
    // ------------------------------------------------------------------
    logic [3:0] code;

    sseg_pattern_decode u_decode (
        .seg_i  (seg_s2_q),
        .code_o (code)
    );

    sseg_state_e      state_q;
    logic [CNT_BITS-1:0] cnt_q;
    logic [WD_BITS-1:0]  wd_q;
    logic [SMP_W-1:0] sample_prev_q;
    logic [15:0]      chars_q;
    logic [15:0]      prev_frame_q;
    logic             prev_valid_q;
    logic [3:0]       mask_q;
    logic [3:0]       digit_valid_q;
    logic             frame_valid_q;
    logic             frame_changed_q;
    logic             sel_error_q;
    logic [CNT_W-1:0] scroll_q;

    logic [3:0]  an_prev;
    logic        an_legal;
    logic        an_multi;
    logic        an_changed;
    logic        same_sample;
    logic        capture;
    logic [1:0]  digit_idx;
    logic [15:0] frame_d;
    logic [3:0]  mask_d;
    logic        frame_differs;

    assign an_prev     = sample_prev_q[SMP_W-1 -: 4];
    assign an_legal    = an_is_onehot(an_s2_q);
    assign an_multi    = (an_s2_q != 4'b0000) && !an_legal;
    assign an_changed  = (an_s2_q != an_prev);
    assign same_sample = (sample == sample_prev_q);
    assign digit_idx   = an_to_digit(an_s2_q);

    // The counter already holds the number of identical samples seen before
    // this one, so this edge brings it to STABLE_CYCLES.
    assign capture = (state_q == ST_SETTLE) && an_legal && same_sample &&
                     (cnt_q == CNT_LAST);

    // Frame contents and capture mask as they will be after this capture.
    always_comb begin
        frame_d = chars_q;
        frame_d[{digit_idx, 2'b00} +: 4] = code;
        mask_d  = mask_q | (4'b0001 << digit_idx);
    end

    assign frame_differs = !prev_valid_q || (frame_d != prev_frame_q);

    // ------------------------------------------------------------------
    // FSM, capture slots, frame tracking and watchdog
    // ------------------------------------------------------------------
`ifdef SSEG_DP_CAPTURE_EN
    logic [3:0] dp_out_q;
`endif

    // Stability FSM with registered outputs; capture updates frame state.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q         <= ST_IDLE;
            cnt_q           <= '0;
            wd_q            <= '0;
            sample_prev_q   <= '0;
            chars_q         <= BLANK_FRAME;
            prev_frame_q    <= BLANK_FRAME;
            prev_valid_q    <= 1'b0;
            mask_q          <= 4'b0000;
            digit_valid_q   <= 4'b0000;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            sel_error_q     <= 1'b0;
            scroll_q        <= '0;
`ifdef SSEG_DP_CAPTURE_EN
            dp_out_q        <= 4'b0000;
`endif
        end else begin
            sample_prev_q   <= sample;
            frame_valid_q   <= 1'b0;
            frame_changed_q <= 1'b0;
            // Only the first cycle of a given multi-hot value is flagged.
            sel_error_q     <= an_multi && an_changed;

            if (!an_legal) begin
                state_q <= ST_IDLE;
                cnt_q   <= '0;
            end else begin
                unique case (state_q)
                    ST_IDLE: begin
                        state_q <= ST_SETTLE;
                        cnt_q   <= CNT_ONE;
                    end
                    ST_SETTLE: begin
                        if (!same_sample) begin
                            cnt_q <= CNT_ONE;
                        end else if (capture) begin
                            state_q <= ST_HOLD;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    ST_HOLD: begin
                        // Segment changes while the same digit is selected
                        // are ignored; only a new anode restarts settling.
                        if (an_changed) begin
                            state_q <= ST_SETTLE;
                            cnt_q   <= CNT_ONE;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        cnt_q   <= '0;
                    end
                endcase
            end

            if (capture) begin
                chars_q                  <= frame_d;
                digit_valid_q[digit_idx] <= 1'b1;
                wd_q                     <= '0;
`ifdef SSEG_DP_CAPTURE_EN
                dp_out_q[digit_idx]      <= ~dp_s2_q;
`endif
                if (mask_d == 4'hF) begin
                    frame_valid_q <= 1'b1;
                    if (frame_differs) begin
                        frame_changed_q <= 1'b1;
                        scroll_q        <= scroll_q + 1'b1;
                    end
                    prev_frame_q <= frame_d;
                    prev_valid_q <= 1'b1;
                    mask_q       <= 4'b0000;
                end else begin
                    mask_q <= mask_d;
                end
            end else if (wd_q == WD_LAST) begin
                // Display went quiet: forget what was seen, keep the text.
                digit_valid_q <= 4'b0000;
                mask_q        <= 4'b0000;
                prev_valid_q  <= 1'b0;
                wd_q          <= '0;
            end else begin
                wd_q <= wd_q + 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign bus.char_out      = chars_q;
    assign bus.digit_valid   = digit_valid_q;
    assign bus.frame_valid   = frame_valid_q;
    assign bus.frame_changed = frame_changed_q;
    assign bus.scroll_count  = scroll_q;
    assign bus.sel_error     = sel_error_q;
`ifdef SSEG_DP_CAPTURE_EN
    assign bus.dp_out        = dp_out_q;
`else
    assign bus.dp_out        = 4'b0000;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sseg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_sseg_scan_decoder
// Description : Self-checking bench for sseg_scan_decoder. A reference model
//               tracks run lengths of identical delayed samples and rebuilds
//               frames from the character table; every cycle the DUT outputs
//               are compared against it, plus directed scenario checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sseg_scan_decoder;

    localparam int STABLE  = 16;
    localparam int TIMEOUT = 600;
    localparam int CNT_W   = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    sseg_scan_decoder_if #(.CNT_W(CNT_W)) bus ();

    sseg_scan_decoder #(
        .STABLE_CYCLES  (STABLE),
        .TIMEOUT_CYCLES (TIMEOUT),
        .CNT_W          (CNT_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    logic [6:0] dec_seg;
    logic [3:0] dec_code;

    sseg_pattern_decode u_dec (
        .seg_i  (dec_seg),
        .code_o (dec_code)
    );

    int checks = 0;
    int errors = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Character table as written down for the display.
    function automatic logic [3:0] ref_code(input logic [6:0] p);
        case (p)
            7'b1000000: return 4'd0;
            7'b0000111: return 4'd1;
            7'b1111111: return 4'd2;
            7'b1111001: return 4'd3;
            7'b0001001: return 4'd4;
            7'b0001000: return 4'd5;
            7'b0010010: return 4'd6;
            7'b1000111: return 4'd7;
            7'b0100100: return 4'd9;
            default:    return 4'hF;
        endcase
    endfunction

    function automatic logic [6:0] ref_pat(input logic [3:0] c);
        case (c)
            4'd0: return 7'b1000000;
            4'd1: return 7'b0000111;
            4'd2: return 7'b1111111;
            4'd3: return 7'b1111001;
            4'd4: return 7'b0001001;
            4'd5: return 7'b0001000;
            4'd6: return 7'b0010010;
            4'd7: return 7'b1000111;
            4'd9: return 7'b0100100;
            default: return 7'b0110110;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // Reference model
    // ------------------------------------------------------------------
    logic [3:0] m_an1, m_an2;
    logic [6:0] m_seg1, m_seg2;
    logic       m_dp1, m_dp2;
    logic [3:0] last_an;
    logic [6:0] last_seg;
    logic       last_dp;
    int         run_len;
    bit         capd;
    logic [3:0] slot [4];
    logic [15:0] prev_frame;
    bit          prev_valid;
    logic [3:0]  mask, e_dv, e_dp;
    int          since;
    logic        e_fv, e_fc, e_sel;
    logic [CNT_W-1:0] e_scroll;

    function automatic logic [15:0] exp_chars();
        return {slot[3], slot[2], slot[1], slot[0]};
    endfunction

    task model_reset();
        m_an1 = 4'b0; m_an2 = 4'b0; m_seg1 = 7'h7F; m_seg2 = 7'h7F; m_dp1 = 1'b1; m_dp2 = 1'b1;
        last_an = 4'b0; last_seg = 7'h0; last_dp = 1'b0;
        run_len = 0; capd = 1'b0;
        for (int i = 0; i < 4; i++) slot[i] = 4'h2;
        prev_frame = 16'h2222; prev_valid = 1'b0;
        mask = 4'b0; e_dv = 4'b0; e_dp = 4'b0; since = 0;
        e_fv = 1'b0; e_fc = 1'b0; e_sel = 1'b0; e_scroll = '0;
    endtask

    task model_step();
        logic [3:0]  an;
        logic [6:0]  seg;
        logic        dp;
        logic        same;
        int          d;
        logic [15:0] frame;
        an = m_an2; seg = m_seg2; dp = m_dp2;
        m_an2 = m_an1; m_seg2 = m_seg1; m_dp2 = m_dp1;
        m_an1 = bus.an; m_seg1 = bus.seg_n; m_dp1 = bus.dp_n;
        e_fv = 1'b0; e_fc = 1'b0; e_sel = 1'b0;
`ifdef SSEG_DP_CAPTURE_EN
        same = (an == last_an) && (seg == last_seg) && (dp == last_dp);
`else
        same = (an == last_an) && (seg == last_seg);
`endif
        run_len = same ? run_len + 1 : 1;
        if (an != last_an) capd = 1'b0;
        if ($countones(an) > 1 && an != last_an) e_sel = 1'b1;
        if ($countones(an) == 1 && run_len == STABLE && !capd) begin
            capd = 1'b1;
            d = 0;
            for (int i = 0; i < 4; i++) if (an[i]) d = 3 - i;
            slot[d] = ref_code(seg);
            e_dv[d] = 1'b1;
`ifdef SSEG_DP_CAPTURE_EN
            e_dp[d] = ~dp;
`endif
            mask[d] = 1'b1;
            since = 0;
            if (mask == 4'hF) begin
                frame = exp_chars();
                e_fv = 1'b1;
                if (!prev_valid || frame != prev_frame) begin
                    e_fc = 1'b1;
                    e_scroll = e_scroll + 1'b1;
                end
                prev_frame = frame;
                prev_valid = 1'b1;
                mask = 4'b0;
            end
        end else if (since == TIMEOUT - 1) begin
            e_dv = 4'b0; mask = 4'b0; prev_valid = 1'b0; since = 0;
        end else begin
            since++;
        end
        last_an = an; last_seg = seg; last_dp = dp;
    endtask

    always @(posedge clock) begin
        if (reset) model_reset();
        else       model_step();
    end

    // ------------------------------------------------------------------
    // Per-cycle comparison and pulse counting
    // ------------------------------------------------------------------
    bit chk_en = 1'b0;
    int fv_seen = 0, fc_seen = 0, sel_seen = 0;

    always @(posedge clock) begin
        #1;
        if (chk_en) begin
            check_eq("char_out", {16'b0, bus.char_out}, {16'b0, exp_chars()});
            check_eq("status", {13'b0, bus.digit_valid, bus.dp_out, bus.frame_valid,
                                bus.frame_changed, bus.sel_error, bus.scroll_count},
                               {13'b0, e_dv, e_dp, e_fv, e_fc, e_sel, e_scroll});
            if (bus.frame_valid)   fv_seen++;
            if (bus.frame_changed) fc_seen++;
            if (bus.sel_error)     sel_seen++;
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers
    // ------------------------------------------------------------------
    task automatic drive(input logic [3:0] a, input logic [6:0] s, input logic d, input int n);
        @(negedge clock);
        bus.an = a; bus.seg_n = s; bus.dp_n = d;
        repeat (n - 1) @(negedge clock);
    endtask

    function automatic logic [3:0] an_for(input int d);
        return 4'b1000 >> d;
    endfunction

    task automatic show_frame(input logic [3:0] c3, input logic [3:0] c2,
                              input logic [3:0] c1, input logic [3:0] c0, input int dwell);
        logic [3:0] codes [4];
        codes[0] = c0; codes[1] = c1; codes[2] = c2; codes[3] = c3;
        for (int d = 0; d < 4; d++) begin
            drive(an_for(d), ref_pat(codes[d]), 1'b1, dwell);
            drive(4'b0000, 7'h7F, 1'b1, 2);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check_eq({tag, "_char"},   {16'b0, bus.char_out}, 32'h2222);
        check_eq({tag, "_dv"},     {28'b0, bus.digit_valid}, 32'h0);
        check_eq({tag, "_dp"},     {28'b0, bus.dp_out}, 32'h0);
        check_eq({tag, "_pulses"}, {29'b0, bus.frame_valid, bus.frame_changed, bus.sel_error}, 32'h0);
        check_eq({tag, "_scroll"}, {24'b0, bus.scroll_count}, 32'h0);
    endtask

    // ------------------------------------------------------------------
    // Main sequence
    // ------------------------------------------------------------------
    initial begin
        int n;
        int fc_before, sel_before;
        logic [3:0] a;
        logic [6:0] p;
        logic [3:0] c;
        logic       dpv;

        bus.an = 4'b0000; bus.seg_n = 7'h7F; bus.dp_n = 1'b1;
        dec_seg = 7'h00;
        repeat (3) @(negedge clock);
        check_reset_values("reset");
        reset = 1'b0;
        chk_en = 1'b1;

        // Stand-alone decoder over every pattern.
        for (int i = 0; i < 128; i++) begin
            dec_seg = 7'(i);
            #1;
            check_eq("decode", {28'b0, dec_code}, {28'b0, ref_code(7'(i))});
        end

        // "SHAA" once round.
        show_frame(4'd6, 4'd4, 4'd5, 4'd5, 40);
        drive(4'b0000, 7'h7F, 1'b1, 5);
        check_eq("shaa_char",   {16'b0, bus.char_out}, 32'h6455);
        check_eq("shaa_scroll", {24'b0, bus.scroll_count}, 32'd1);
        check_eq("shaa_fv",     fv_seen, 1);
        check_eq("shaa_fc",     fc_seen, 1);

        // Scroll to "HAAS", then repeat it.
        show_frame(4'd4, 4'd5, 4'd5, 4'd6, 40);
        drive(4'b0000, 7'h7F, 1'b1, 5);
        check_eq("haas_char",   {16'b0, bus.char_out}, 32'h4556);
        check_eq("haas_scroll", {24'b0, bus.scroll_count}, 32'd2);
        check_eq("haas_fc",     fc_seen, 2);
        show_frame(4'd4, 4'd5, 4'd5, 4'd6, 40);
        drive(4'b0000, 7'h7F, 1'b1, 5);
        check_eq("repeat_fv",     fv_seen, 3);
        check_eq("repeat_fc",     fc_seen, 2);
        check_eq("repeat_scroll", {24'b0, bus.scroll_count}, 32'd2);

        // Quiet display -> watchdog.
        drive(4'b0000, 7'h7F, 1'b1, TIMEOUT + 20);
        check_eq("timeout_dv",   {28'b0, bus.digit_valid}, 32'h0);
        check_eq("timeout_char", {16'b0, bus.char_out}, 32'h4556);

        // Glitching segments on digit 0 never settle.
        for (int k = 0; k < 8; k++) begin
            drive(4'b1000, ref_pat(4'd5), 1'b1, 10);
            drive(4'b1000, ref_pat(4'd7), 1'b1, 10);
        end
        check_eq("glitch_dv0", {31'b0, bus.digit_valid[0]}, 32'h0);
        @(negedge clock);
        bus.seg_n = ref_pat(4'd5);
        n = 0;
        while (!bus.digit_valid[0] && n < 200) begin
            @(posedge clock);
            #1;
            n++;
        end
        check_eq("glitch_latency", n, STABLE + 2);

        // First full frame after the timeout counts as a change.
        fc_before = fc_seen;
        drive(4'b0000, 7'h7F, 1'b1, 3);
        show_frame(4'd4, 4'd5, 4'd5, 4'd6, 40);
        drive(4'b0000, 7'h7F, 1'b1, 5);
        check_eq("post_timeout_fc",     fc_seen - fc_before, 1);
        check_eq("post_timeout_scroll", {24'b0, bus.scroll_count}, 32'd3);

        // Two anodes at once.
        sel_before = sel_seen;
        drive(4'b1100, ref_pat(4'd0), 1'b1, 20);
        drive(4'b0000, 7'h7F, 1'b1, 3);
        check_eq("sel_pulses", sel_seen - sel_before, 1);
        check_eq("sel_char",   {16'b0, bus.char_out}, 32'h4556);

        // Shared 5/8 pattern and an unknown pattern.
        drive(4'b1000, 7'b0001000, 1'b1, 30);
        drive(4'b0000, 7'h7F, 1'b1, 2);
        drive(4'b0100, 7'b0110110, 1'b1, 30);
        drive(4'b0000, 7'h7F, 1'b1, 2);
        check_eq("code_5",       {28'b0, bus.char_out[3:0]}, 32'h5);
        check_eq("code_illegal", {28'b0, bus.char_out[7:4]}, 32'hF);

        // Decimal point lit on digit 2 only.
        drive(4'b0010, ref_pat(4'd1), 1'b0, 30);
        drive(4'b0000, 7'h7F, 1'b1, 2);
`ifdef SSEG_DP_CAPTURE_EN
        check_eq("dp_out", {28'b0, bus.dp_out}, 32'h4);
`else
        check_eq("dp_out", {28'b0, bus.dp_out}, 32'h0);
`endif

        // Reset in the middle of settling.
        drive(4'b1000, ref_pat(4'd3), 1'b1, STABLE / 2);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_reset_values("midreset");
        @(negedge clock);
        reset = 1'b0;

        // Randomised scanning with ghosts, glitches, bad selects and gaps.
        for (int f = 0; f < 50; f++) begin
            for (int d = 0; d < 4; d++) begin
                if ($urandom_range(0, 14) == 0) begin
                    a = 4'($urandom_range(0, 15));
                    if ($countones(a) < 2) a = 4'b1100;
                    drive(a, 7'($urandom_range(0, 127)), 1'b1, $urandom_range(1, 4));
                end
                n = $urandom_range(0, 3);
                if (n > 0) drive(4'b0000, 7'h7F, 1'b1, n);
                c = 4'($urandom_range(0, 9));
                if (c == 4'd8) c = 4'd7;
                p = ($urandom_range(0, 9) == 0) ? 7'($urandom_range(0, 127)) : ref_pat(c);
                dpv = 1'($urandom_range(0, 1));
                if ($urandom_range(0, 3) == 0)
                    drive(an_for(d), p ^ 7'(1 << $urandom_range(0, 6)), dpv, $urandom_range(1, 12));
                drive(an_for(d), p, dpv, $urandom_range(8, 40));
            end
            if ($urandom_range(0, 9) == 0)
                drive(4'b0000, 7'h7F, 1'b1, TIMEOUT + $urandom_range(0, 50));
        end
        drive(4'b0000, 7'h7F, 1'b1, 5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
